// File: rtl/poly_mac_accum_if.sv
// Request/result bundle between the multiply sequencer and its requester.
//
// Handshake: the master raises start together with a stable b_in. The request
// is accepted only while busy is low and the block is idle. Once accepted,
// busy stays high through the load and run phases, and further starts are
// dropped rather than queued. done pulses for one cycle when result becomes
// valid. result then holds until the next done pulse.
interface poly_mac_accum_if #(
  parameter int ACC_W = 2
);
  logic               start;
  logic [7:0]         b_in;
  logic               busy;
  logic               done;
  logic [4*ACC_W-1:0] result;

  modport master (
    output start, b_in,
    input  busy, done, result
  );

  modport slave (
    input  start, b_in,
    output busy, done, result
  );
endinterface

// File: rtl/poly_mac_accum.sv
// Sequencer and multiply-accumulate stage for a 4-term cyclic polynomial
// product C = A*B mod (x^4 - 1).
// Operand A is held in an external rotating coefficient register, which this
// block loads and then rotates. Operand B is captured locally when a request
// is accepted. On each of four run cycles, every A slot is multiplied by one
// B coefficient and the product is added into its own accumulator.
module poly_mac_accum #(
  parameter int ACC_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  poly_mac_accum_if.slave      bus,
  input  logic [1:0]           coef0,
  input  logic [1:0]           coef1,
  input  logic [1:0]           coef2,
  input  logic [1:0]           coef3,
  output logic                 csr_load,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [1:0]         step_q;
  logic [7:0]         b_q;
  logic [ACC_W-1:0]   acc_q [4];
  logic [4*ACC_W-1:0] result_q;
  logic               busy_q;
  logic               done_q;
  logic               load_q;

  logic [1:0]         coef_w [4];
  logic [1:0]         bidx_w;
  logic [1:0]         bsel_w;
  logic [3:0]         prod_w [4];
  logic [7:0]         prod_ext_w [4];
  logic [ACC_W-1:0]   acc_d [4];

  // One B coefficient per step is selected, in the order b0, b3, b2, b1.
  // Because the register rotates by one slot each step, this order lines up
  // with the cyclic convolution. Each 4-bit product is truncated or
  // zero-extended to the accumulator width, and the sum wraps.
  always_comb begin
    coef_w[0] = coef0;
    coef_w[1] = coef1;
    coef_w[2] = coef2;
    coef_w[3] = coef3;
    bidx_w    = 2'd0 - step_q;
    bsel_w    = b_q[{bidx_w, 1'b0} +: 2];
    for (int i = 0; i < 4; i++) begin
      prod_w[i]     = {2'b00, coef_w[i]} * {2'b00, bsel_w};
      prod_ext_w[i] = {4'b0000, prod_w[i]};
      acc_d[i]      = acc_q[i] + prod_ext_w[i][ACC_W-1:0];
    end
  end

  // Control FSM: state, step counter, operand capture, accumulators and all
  // outputs are registered. No output depends combinationally on an input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      step_q   <= 2'd0;
      b_q      <= 8'd0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      load_q   <= 1'b0;
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= S_LOAD;
            b_q     <= bus.b_in;
            step_q  <= 2'd0;
            busy_q  <= 1'b1;
            load_q  <= 1'b1;
            for (int i = 0; i < 4; i++) acc_q[i] <= '0;
          end
        end
        S_LOAD: begin
          // The coefficient register captures A at the end of this cycle.
          load_q  <= 1'b0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          for (int i = 0; i < 4; i++) acc_q[i] <= acc_d[i];
          step_q <= step_q + 2'd1;
          if (step_q == 2'd3) begin
            // Take the result from the final sum so that it is valid during DONE.
            for (int i = 0; i < 4; i++) result_q[i*ACC_W +: ACC_W] <= acc_d[i];
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign csr_load   = load_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_poly_mac_accum.sv
// Directed bench for poly_mac_accum. A behavioural model of the rotating
// coefficient register feeds two instances: one with ACC_W=2 and one with
// ACC_W=4.
module tb_poly_mac_accum;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  poly_mac_accum_if #(.ACC_W(2)) bus ();
  poly_mac_accum_if #(.ACC_W(4)) bus4 ();

  logic       csr_load, csr_load4;
  logic [1:0] state_dbg, state_dbg4;
  logic [1:0] csr [4];
  logic [7:0] a_vec;

  assign bus4.start = bus.start;
  assign bus4.b_in  = bus.b_in;

  poly_mac_accum #(.ACC_W(2)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .coef0(csr[0]), .coef1(csr[1]), .coef2(csr[2]), .coef3(csr[3]),
    .csr_load(csr_load), .state_dbg(state_dbg)
  );

  poly_mac_accum #(.ACC_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4),
    .coef0(csr[0]), .coef1(csr[1]), .coef2(csr[2]), .coef3(csr[3]),
    .csr_load(csr_load4), .state_dbg(state_dbg4)
  );

  // Coefficient register model: load A on csr_load, otherwise rotate so that slot i takes slot i+1.
  always @(posedge clk) begin
    if (csr_load) begin
      for (int k = 0; k < 4; k++) csr[k] <= a_vec[2*k +: 2];
    end else begin
      for (int k = 0; k < 4; k++) csr[k] <= csr[(k+1)%4];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // One full operation starting in the current idle cycle (cycle 0); the task returns in cycle 7.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input logic [15:0] exp4, input bit chk4);
    a_vec     = a;
    bus.start = 1'b1;
    bus.b_in  = b;
    check({tag, " busy c0"}, 32'(bus.busy), 32'd0);
    tick();
    bus.start = 1'b0;
    check({tag, " csr_load c1"}, 32'(csr_load), 32'd1);
    check({tag, " busy c1"}, 32'(bus.busy), 32'd1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check({tag, " busy run"}, 32'(bus.busy), 32'd1);
      check({tag, " csr_load run"}, 32'(csr_load), 32'd0);
      check({tag, " done run"}, 32'(bus.done), 32'd0);
    end
    tick();
    check({tag, " done c6"}, 32'(bus.done), 32'd1);
    check({tag, " busy c6"}, 32'(bus.busy), 32'd0);
    check({tag, " result"}, 32'(bus.result), 32'(exp));
    if (chk4) check({tag, " result w4"}, 32'(bus4.result), 32'(exp4));
    tick();
    check({tag, " done c7"}, 32'(bus.done), 32'd0);
    check({tag, " result held"}, 32'(bus.result), 32'(exp));
  endtask

  logic [20:0] done_bits, load_bits;
  int          done_cnt;

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.b_in  = 8'd0;
    a_vec     = 8'd0;
    tick();
    tick();
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset csr_load", 32'(csr_load), 32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    check("reset state", 32'(state_dbg), 32'd0);
    reset = 1'b1;
    tick();

    // Identity: A=1, B=[1,2,3,0].
    run_op("identity", 8'h01, 8'h39, 8'h39, 16'h0321, 1'b1);
    // Cyclic wrap: A=x, B=1+x^3 gives c=[1,1,0,0].
    run_op("wrap", 8'h04, 8'h41, 8'h05, 16'h0011, 1'b1);
    // A=3, B=3: c0 = 9 mod 4.
    run_op("mod scalar", 8'h03, 8'h03, 8'h01, 16'h0009, 1'b1);
    // All-threes: each c_k=36 -> 0 (mod 4), 4 (mod 16).
    run_op("mod all3", 8'hFF, 8'hFF, 8'h00, 16'h4444, 1'b1);
    // Mixed: A=[1,2,0,3], B=[2,1,3,1] -> c=[7,14,8,13] raw.
    run_op("mixed", 8'hC9, 8'h76, 8'h4B, 16'hD8E7, 1'b1);

    // Start while busy: pulse in cycle 3 with another B is ignored.
    a_vec     = 8'h01;
    bus.start = 1'b1;
    bus.b_in  = 8'h39;
    done_cnt  = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      bus.start = (c == 3);
      bus.b_in  = (c == 3) ? 8'hFF : 8'h39;
      if (bus.done) done_cnt++;
      if (c == 6) check("busy-start result", 32'(bus.result), 32'h39);
      if (c == 8) check("busy-start no requeue", 32'(bus.busy), 32'd0);
    end
    bus.start = 1'b0;
    check("busy-start done count", 32'(done_cnt), 32'd1);

    // Reset in the middle of a run.
    a_vec     = 8'h01;
    bus.start = 1'b1;
    bus.b_in  = 8'h41;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("mid busy before reset", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid reset busy", 32'(bus.busy), 32'd0);
    check("mid reset done", 32'(bus.done), 32'd0);
    check("mid reset csr_load", 32'(csr_load), 32'd0);
    check("mid reset result", 32'(bus.result), 32'd0);
    check("mid reset state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    run_op("post-reset identity", 8'h01, 8'h39, 8'h39, 16'h0321, 1'b1);

    // Continuous start over cycles 0..13: two back-to-back operations.
    a_vec     = 8'h01;
    bus.b_in  = 8'h39;
    done_bits = '0;
    load_bits = '0;
    for (int c = 0; c <= 20; c++) begin
      bus.start    = (c <= 13);
      done_bits[c] = bus.done;
      load_bits[c] = csr_load;
      tick();
    end
    bus.start = 1'b0;
    check("continuous done cycles", 32'(done_bits), 32'h0002040);
    check("continuous load cycles", 32'(load_bits), 32'h0000102);
    check("continuous result", 32'(bus.result), 32'h39);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
